ama_riscv_mem_stage: RTL and testbench

AMA_RISCV_MEM_STAGE -- requirements
Module: ama_riscv_mem_stage

---
 rtl/ama_riscv_mem_stage_if.sv | 14 +
 rtl/ama_riscv_mem_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_ama_riscv_mem_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ama_riscv_mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and DMEM (slave).
interface ama_riscv_mem_stage_if #(
  parameter int DMEM_AW = 14
) ();
  logic               req;
  logic [3:0]         we;
  logic [DMEM_AW-1:0] addr;
  logic [31:0]        wdata;
  logic               rvalid;
  logic [31:0]        rdata;

  modport master (output req, we, addr, wdata, input rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output rvalid, rdata);
endinterface

// File: rtl/ama_riscv_mem_stage.sv
// RISC-V MEM stage: one outstanding DMEM access, load extract, store lane alignment, writeback.
// state | meaning:  IDLE | ready for EX;  BUSY | DMEM access outstanding, waiting for rvalid
module ama_riscv_mem_stage #(
  parameter int DMEM_AW = 14,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ex_valid,
  output logic                          ex_ready,
  input  logic [31:0]                   ex_alu_out,
  input  logic [31:0]                   ex_rs2_data,
  input  logic [31:0]                   ex_pc_inc4,
  input  logic [2:0]                    ex_funct3,
  input  logic                          ex_load,
  input  logic                          ex_store,
  input  logic [1:0]                    ex_wb_sel,
  input  logic [4:0]                    ex_rd,
  input  logic                          ex_reg_we,
  ama_riscv_mem_stage_if.master         dmem,
  output logic                          wb_en,
  output logic [4:0]                    wb_rd,
  output logic [31:0]                   wb_data,
  output logic                          err_misalign,
  output logic                          err_timeout
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [3:0]         we_q, we_d;
  logic [DMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         boff_q, boff_d;
  logic [4:0]         rd_q, rd_d;
  logic               reg_we_q, reg_we_d;
  logic               is_load_q, is_load_d;
  logic               sel_dmem_q, sel_dmem_d;
  logic [31:0]        alt_q, alt_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               wb_en_q, wb_en_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               err_mis_q, err_mis_d;
  logic               err_to_q, err_to_d;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic        bad_access;
  logic [31:0] alu_or_pc;

  always_comb begin
    case (boff_q)
      2'd0:    ld_byte = dmem.rdata[7:0];
      2'd1:    ld_byte = dmem.rdata[15:8];
      2'd2:    ld_byte = dmem.rdata[23:16];
      default: ld_byte = dmem.rdata[31:24];
    endcase
    ld_half = boff_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = dmem.rdata;
    endcase
  end

  always_comb begin
    case (ex_funct3[1:0])
      2'b00: begin
        st_we    = 4'b0001 << ex_alu_out[1:0];
        st_wdata = {4{ex_rs2_data[7:0]}};
      end
      2'b01: begin
        st_we    = 4'b0011 << {ex_alu_out[1], 1'b0};
        st_wdata = {2{ex_rs2_data[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = ex_rs2_data;
      end
    endcase
    // size 2'b11 is never legal, so it folds into the misalign error
    case (ex_funct3[1:0])
      2'b01:   bad_access = ex_alu_out[0];
      2'b10:   bad_access = |ex_alu_out[1:0];
      2'b11:   bad_access = 1'b1;
      default: bad_access = 1'b0;
    endcase
    if (ex_load && ex_funct3[2:1] == 2'b11)
      bad_access = 1'b1;
    if (!ex_load && ex_store && ex_funct3[2])
      bad_access = 1'b1;
    alu_or_pc = (ex_wb_sel == 2'd2) ? ex_pc_inc4 : ex_alu_out;
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    boff_d     = boff_q;
    rd_d       = rd_q;
    reg_we_d   = reg_we_q;
    is_load_d  = is_load_q;
    sel_dmem_d = sel_dmem_q;
    alt_d      = alt_q;
    cnt_d      = cnt_q;
    wb_en_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_mis_d  = 1'b0;
    err_to_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (ex_load || ex_store) begin
            if (bad_access) begin
              err_mis_d = 1'b1;
            end else begin
              state_d    = BUSY;
              req_d      = 1'b1;
              we_d       = ex_load ? 4'b0000 : st_we;
              addr_d     = ex_alu_out[DMEM_AW+1:2];
              wdata_d    = ex_load ? 32'b0 : st_wdata;
              funct3_d   = ex_funct3;
              boff_d     = ex_alu_out[1:0];
              rd_d       = ex_rd;
              reg_we_d   = ex_reg_we;
              is_load_d  = ex_load;
              sel_dmem_d = (ex_wb_sel == 2'd0);
              alt_d      = alu_or_pc;
              cnt_d      = 8'd0;
            end
          end else begin
            wb_en_d   = ex_reg_we && (ex_rd != 5'd0);
            wb_rd_d   = ex_rd;
            wb_data_d = alu_or_pc;
          end
        end
      end
      BUSY: begin
        if (dmem.rvalid) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 4'b0000;
          if (is_load_q) begin
            wb_en_d   = reg_we_q && (rd_q != 5'd0);
            wb_rd_d   = rd_q;
            wb_data_d = sel_dmem_q ? ld_data : alt_q;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d  = IDLE;
          req_d    = 1'b0;
          we_d     = 4'b0000;
          err_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 4'b0;
      addr_q     <= '0;
      wdata_q    <= 32'b0;
      funct3_q   <= 3'b0;
      boff_q     <= 2'b0;
      rd_q       <= 5'b0;
      reg_we_q   <= 1'b0;
      is_load_q  <= 1'b0;
      sel_dmem_q <= 1'b0;
      alt_q      <= 32'b0;
      cnt_q      <= 8'b0;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= 5'b0;
      wb_data_q  <= 32'b0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      boff_q     <= boff_d;
      rd_q       <= rd_d;
      reg_we_q   <= reg_we_d;
      is_load_q  <= is_load_d;
      sel_dmem_q <= sel_dmem_d;
      alt_q      <= alt_d;
      cnt_q      <= cnt_d;
      wb_en_q    <= wb_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_mis_q  <= err_mis_d;
      err_to_q   <= err_to_d;
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign dmem.req     = req_q;
  assign dmem.we      = we_q;
  assign dmem.addr    = addr_q;
  assign dmem.wdata   = wdata_q;
  assign wb_en        = wb_en_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign err_misalign = err_mis_q;
  assign err_timeout  = err_to_q;
endmodule

// File: tb/tb_ama_riscv_mem_stage.sv
// Directed self-checking bench for ama_riscv_mem_stage (TIMEOUT=8).
module tb_ama_riscv_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_alu_out = '0, ex_rs2_data = '0, ex_pc_inc4 = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_load = 1'b0, ex_store = 1'b0;
  logic [1:0]  ex_wb_sel = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_we = 1'b0;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_misalign, err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  ama_riscv_mem_stage_if #(.DMEM_AW(14)) dmem_if ();

  ama_riscv_mem_stage #(.DMEM_AW(14), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data), .ex_pc_inc4(ex_pc_inc4),
    .ex_funct3(ex_funct3), .ex_load(ex_load), .ex_store(ex_store),
    .ex_wb_sel(ex_wb_sel), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .dmem(dmem_if),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting posedge
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc,
                       input logic [1:0] sel, input logic [4:0] rd, input logic we);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_alu_out = alu; ex_rs2_data = rs2; ex_pc_inc4 = pc;
    ex_wb_sel = sel; ex_rd = rd; ex_reg_we = we;
    @(negedge clk);
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
  endtask

  task automatic do_alu(input string tag, input logic [1:0] sel, input logic [4:0] rd,
                        input logic we, input logic [31:0] alu, input logic [31:0] pc,
                        input logic exp_en, input logic [31:0] exp_data);
    issue(1'b0, 1'b0, 3'b000, alu, 32'h0, pc, sel, rd, we);
    chk({tag, " wb_en"}, wb_en, exp_en);
    if (exp_en) begin
      chk({tag, " wb_rd"}, wb_rd, rd);
      chk({tag, " wb_data"}, wb_data, exp_data);
    end
    chk({tag, " ready"}, ex_ready, 1'b1);
    @(negedge clk);
    chk({tag, " wb_en pulse"}, wb_en, 1'b0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input int dly, input logic [31:0] exp);
    logic [31:0] wa;
    int busy;
    wa = {18'b0, addr[15:2]};
    busy = 0;
    issue(1'b1, 1'b0, f3, addr, 32'h0, 32'h0, 2'd0, 5'd7, 1'b1);
    chk({tag, " req"}, dmem_if.req, 1'b1);
    chk({tag, " addr"}, dmem_if.addr, wa);
    chk({tag, " we"}, dmem_if.we, 4'b0000);
    for (int i = 0; i < dly; i++) begin
      if (!ex_ready) busy++;
      if (dmem_if.req !== 1'b1 || dmem_if.addr !== wa[13:0]) chk({tag, " hold"}, {dmem_if.req, 17'b0, dmem_if.addr}, {1'b1, 17'b0, wa[13:0]});
      chk({tag, " no wb in busy"}, wb_en, 1'b0);
      @(negedge clk);
    end
    dmem_if.rvalid = 1'b1; dmem_if.rdata = rdata;
    if (!ex_ready) busy++;
    @(negedge clk);
    dmem_if.rvalid = 1'b0; dmem_if.rdata = 32'h0;
    chk({tag, " busy cycles"}, busy, dly + 1);
    chk({tag, " req drop"}, dmem_if.req, 1'b0);
    chk({tag, " ready"}, ex_ready, 1'b1);
    chk({tag, " wb_en"}, wb_en, 1'b1);
    chk({tag, " wb_rd"}, wb_rd, 5'd7);
    chk({tag, " wb_data"}, wb_data, exp);
    @(negedge clk);
    chk({tag, " wb_en pulse"}, wb_en, 1'b0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] exp_we,
                          input logic [31:0] exp_wd);
    issue(1'b0, 1'b1, f3, addr, data, 32'h0, 2'd1, 5'd0, 1'b0);
    chk({tag, " req"}, dmem_if.req, 1'b1);
    chk({tag, " we"}, dmem_if.we, exp_we);
    chk({tag, " wdata"}, dmem_if.wdata, exp_wd);
    chk({tag, " addr"}, dmem_if.addr, {18'b0, addr[15:2]});
    dmem_if.rvalid = 1'b1;
    @(negedge clk);
    dmem_if.rvalid = 1'b0;
    chk({tag, " req drop"}, dmem_if.req, 1'b0);
    chk({tag, " no wb"}, wb_en, 1'b0);
    chk({tag, " ready"}, ex_ready, 1'b1);
    @(negedge clk);
    chk({tag, " no wb later"}, wb_en, 1'b0);
  endtask

  task automatic do_bad(input string tag, input logic ld, input logic [2:0] f3, input logic [31:0] addr);
    issue(ld, ~ld, f3, addr, 32'h55, 32'h0, 2'd0, 5'd9, 1'b1);
    chk({tag, " err"}, err_misalign, 1'b1);
    chk({tag, " no req"}, dmem_if.req, 1'b0);
    chk({tag, " ready"}, ex_ready, 1'b1);
    chk({tag, " no wb"}, wb_en, 1'b0);
    @(negedge clk);
    chk({tag, " err pulse"}, err_misalign, 1'b0);
    chk({tag, " still no req"}, dmem_if.req, 1'b0);
  endtask

  initial begin
    int n;
    dmem_if.rvalid = 1'b0;
    dmem_if.rdata  = 32'h0;
    #12;
    chk("rst ready", ex_ready, 1'b1);
    chk("rst req", dmem_if.req, 1'b0);
    chk("rst we", dmem_if.we, 4'b0);
    chk("rst wb_en", wb_en, 1'b0);
    chk("rst wb_data", wb_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post-rst ready", ex_ready, 1'b1);

    do_alu("alu", 2'd1, 5'd5, 1'b1, 32'h1234_5678, 32'h0000_0104, 1'b1, 32'h1234_5678);
    do_alu("pc4", 2'd2, 5'd6, 1'b1, 32'h1234_5678, 32'h0000_0104, 1'b1, 32'h0000_0104);
    do_alu("sel3", 2'd3, 5'd8, 1'b1, 32'hCAFE_0001, 32'h0000_0104, 1'b1, 32'hCAFE_0001);
    do_alu("rd0", 2'd1, 5'd0, 1'b1, 32'h1111_1111, 32'h0, 1'b0, 32'h0);
    do_alu("we0", 2'd1, 5'd4, 1'b0, 32'h2222_2222, 32'h0, 1'b0, 32'h0);

    do_load("lb", 3'b000, 32'h0000_1003, 32'h80FF_0000, 0, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_1001, 32'h0000_9A00, 0, 32'h0000_009A);
    do_load("lh", 3'b001, 32'h0000_0040, 32'h1234_8001, 0, 32'hFFFF_8001);
    do_load("lhu dly5", 3'b101, 32'h0000_0042, 32'h8001_7FFE, 5, 32'h0000_8001);
    do_load("lw", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);

    do_store("sh", 3'b001, 32'h0000_2002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    do_store("sb", 3'b000, 32'h0000_5001, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
    do_store("sw", 3'b010, 32'h0000_6004, 32'h0102_0304, 4'b1111, 32'h0102_0304);

    do_bad("lw mis", 1'b1, 3'b010, 32'h0000_3001);
    do_bad("sh mis", 1'b0, 3'b001, 32'h0000_3003);
    do_bad("ld f3 110", 1'b1, 3'b110, 32'h0000_3000);
    do_bad("st f3 100", 1'b0, 3'b100, 32'h0000_3000);

    // no completion: expect timeout after 8 BUSY cycles
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h0, 2'd0, 5'd3, 1'b1);
    n = 0;
    for (int i = 0; i < 20 && !err_timeout; i++) begin
      if (dmem_if.req) n++;
      chk("to no wb", wb_en, 1'b0);
      @(negedge clk);
    end
    chk("to seen", err_timeout, 1'b1);
    chk("to busy cycles", n, 8);
    chk("to req low", dmem_if.req, 1'b0);
    chk("to idle", ex_ready, 1'b1);
    @(negedge clk);
    chk("to pulse", err_timeout, 1'b0);

    // reset in the middle of BUSY
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0, 2'd0, 5'd9, 1'b1);
    chk("mid-rst busy", dmem_if.req, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("mid-rst req async", dmem_if.req, 1'b0);
    chk("mid-rst ready", ex_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    dmem_if.rvalid = 1'b1; dmem_if.rdata = 32'h7777_7777;
    @(negedge clk);
    dmem_if.rvalid = 1'b0;
    chk("mid-rst no wb", wb_en, 1'b0);
    chk("mid-rst wb_data", wb_data, 32'h0);
    chk("mid-rst req", dmem_if.req, 1'b0);
    @(negedge clk);
    chk("mid-rst no wb later", wb_en, 1'b0);

    // stage usable again after reset
    do_load("lb post-rst", 3'b000, 32'h0000_0002, 32'h0055_0000, 2, 32'h0000_0055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
